fetch_sequencer: RTL and testbench

//  Sequences instruction fetch around the next-PC calculator: owns the architectural PC register,

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_pc_reg.sv | 25 ++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, default reset PC and
// instruction word width. Imported by fetch_sequencer and pc_reg.
// No ports; types and constants only.
package fetch_sequencer_pkg;

  localparam int unsigned    INST_W           = 32;
  localparam logic [31:0]    DEFAULT_RESET_PC = 32'h0000_3000;

  // ST_TRAP is only reachable when FETCH_ALIGN_CHECK_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_TRAP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Purpose: architectural PC register, sync reset to RESET_PC, load-enabled update.
// Latency: load_val appears on pc one cycle after load_en.
// Backpressure: none; holds value whenever load_en is low.
// Ports: clk, rst (sync, active-high), load_en, load_val[31:0], pc[31:0].
module pc_reg
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_val,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_val;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: owns the PC, issues one imem request per PC, holds the returned word for decode.
// Latency: zero-wait imem gives inst_valid 2 cycles after REQ entry; 1 instruction per 3 cycles.
// Backpressure: request held stable until imem_req_ready; inst held until inst_ready & !stall.
// Ports: clk, rst (sync, active-high); next_pc/stall from NPC/hazard logic;
//   imem_req_valid/imem_req_ready/imem_addr request channel; imem_rsp_valid/imem_rsp_data
//   response pulse; pc, inst_valid/inst/inst_ready to decode; fetch_misalign sticky flag.
// Config: define FETCH_ALIGN_CHECK_EN to trap on a misaligned next_pc; otherwise next_pc
//   is force-aligned and fetch_misalign is tied low.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       next_pc,
  input  logic              stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic [31:0]       pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  input  logic              inst_ready,
  output logic              fetch_misalign
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic              pc_load;
  logic [31:0]       pc_load_val;
  logic              inst_cap;
  logic [INST_W-1:0] inst_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_set;
`endif

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (pc_load),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response data is only captured in WAIT; pulses seen in other states are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= '0;
    end else if (inst_cap) begin
      inst_q <= imem_rsp_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    // Low bits are masked so the next fetch is always word aligned.
    pc_load_val = next_pc & ~32'h0000_0003;
    inst_cap    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          inst_cap = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // stall takes priority over inst_ready: the instruction is not retired.
        if (inst_ready && !stall) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
          // The faulting PC is kept unmasked so the handler sees the bad target.
          if (next_pc[1:0] != 2'b00) begin
            pc_load_val  = next_pc;
            misalign_set = 1'b1;
            state_d      = ST_TRAP;
          end
`endif
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (misalign_set) begin
      misalign_q <= 1'b1;
    end
  end
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_addr      = pc;
  assign inst_valid     = (state_q == ST_HOLD);
  assign inst           = inst_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: imem and decode are modelled at the transaction level;
// the expected fetch address stream is derived from the consumed next_pc values.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        fetch_misalign;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus knobs (percentages / delay range)
  int          rdy_pct, min_dly, max_dly, irdy_pct, stall_pct, br_pct, junk_pct;
  bit          npc_force;
  logic [31:0] npc_val;

  // reference model state
  bit          pend;
  int          dly;
  logic [31:0] pend_addr;
  logic [31:0] exp_addr;
  int          req_cnt;
  bit          trapped;
  bit          prev_req_wait, prev_hold_wait;
  logic [31:0] prev_addr, prev_inst, prev_pc;
  int          n_consumed;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_ready     (inst_ready),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic set_knobs(input int rdy, input int dmin, input int dmax, input int irdy,
                           input int stl, input int br, input int junk);
    rdy_pct = rdy; min_dly = dmin; max_dly = dmax; irdy_pct = irdy;
    stall_pct = stl; br_pct = br; junk_pct = junk;
  endtask

  // Must be called at a falling edge; leaves the DUT one cycle into IDLE.
  task automatic do_reset(input int n);
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; stall = 1'b0; next_pc = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    pend = 1'b0; dly = 0; exp_addr = RST_PC; req_cnt = 0; trapped = 1'b0;
    prev_req_wait = 1'b0; prev_hold_wait = 1'b0;
  endtask

  // One cycle: sample at the falling edge, score, then drive inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (prev_req_wait) begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr)
        begin n_err++; $display("FAIL req_stable: valid=%b addr=%h, need valid=1 addr=%h", imem_req_valid, imem_addr, prev_addr); end
    end
    if (prev_hold_wait) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== prev_inst || pc !== prev_pc)
        begin n_err++; $display("FAIL hold_stable: iv=%b inst=%h pc=%h, need iv=1 inst=%h pc=%h", inst_valid, inst, pc, prev_inst, prev_pc); end
    end
    // imem response side
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend) begin
      if (dly == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend = 1'b0;
      end else begin
        dly--;
      end
    end else if ($urandom_range(99) < junk_pct) begin
      imem_rsp_valid = 1'b1;
    end
    // NPC calculator
    if (npc_force) next_pc = npc_val;
    else if ($urandom_range(99) < br_pct) next_pc = $urandom & ~32'h3;
    else next_pc = pc + 32'd4;
    // imem request side
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    prev_req_wait  = imem_req_valid && !imem_req_ready;
    prev_addr      = imem_addr;
    if (imem_req_valid && imem_req_ready) begin
      n_cmp++;
      if (imem_addr !== exp_addr)
        begin n_err++; $display("FAIL req_addr: got %h, need %h", imem_addr, exp_addr); end
      n_cmp++;
      if (req_cnt != 0 || trapped)
        begin n_err++; $display("FAIL single_req: extra request at %h (count %0d, trapped %0d), need none", imem_addr, req_cnt, trapped); end
      req_cnt++;
      pend = 1'b1;
      pend_addr = imem_addr;
      dly = $urandom_range(max_dly, min_dly);
    end
    // decode side
    inst_ready = ($urandom_range(99) < irdy_pct);
    stall      = ($urandom_range(99) < stall_pct);
    if (inst_valid && inst_ready && !stall) begin
      n_cmp++;
      if (inst !== mem_word(exp_addr) || pc !== exp_addr)
        begin n_err++; $display("FAIL consume: inst=%h pc=%h, need inst=%h pc=%h", inst, pc, mem_word(exp_addr), exp_addr); end
`ifdef FETCH_ALIGN_CHECK_EN
      if (next_pc[1:0] != 2'b00) trapped = 1'b1;
      exp_addr = next_pc;
`else
      exp_addr = {next_pc[31:2], 2'b00};
`endif
      req_cnt = 0;
      n_consumed++;
    end
    prev_hold_wait = inst_valid && !(inst_ready && !stall);
    prev_inst = inst;
    prev_pc   = pc;
  endtask

  task automatic run_to_req(output logic [31:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (imem_req_valid && imem_req_ready) begin
        a  = imem_addr;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    npc_force = 1'b0;
    do_reset(2);
    n_cmp++;
    if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h, need %h", pc, RST_PC); end
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_misalign !== 1'b0)
      begin n_err++; $display("FAIL reset_valids: req=%b iv=%b mis=%b, need 0 0 0", imem_req_valid, inst_valid, fetch_misalign); end
    n_cmp++;
    if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h, need 0", inst); end
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
      begin n_err++; $display("FAIL first_req: valid=%b addr=%h, need 1 %h", imem_req_valid, imem_addr, RST_PC); end
  endtask

  task automatic test_back_to_back();
    set_knobs(100, 0, 0, 100, 0, 0, 0);
    npc_force = 1'b0;
    do_reset(1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_cmp++;
      if (imem_req_valid !== (k % 3 == 1) || inst_valid !== (k % 3 == 0))
        begin n_err++; $display("FAIL stream_timing k=%0d: req=%b iv=%b, need req=%b iv=%b", k, imem_req_valid, inst_valid, (k % 3 == 1), (k % 3 == 0)); end
      if (k % 3 == 1) begin
        n_cmp++;
        if (imem_addr !== RST_PC + 32'd4 * ((k - 1) / 3))
          begin n_err++; $display("FAIL stream_addr k=%0d: got %h, need %h", k, imem_addr, RST_PC + 32'd4 * ((k - 1) / 3)); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    set_knobs(0, 0, 0, 0, 0, 0, 0);
    npc_force = 1'b0;
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
        begin n_err++; $display("FAIL bp_req k=%0d: valid=%b addr=%h, need 1 %h", k, imem_req_valid, imem_addr, RST_PC); end
    end
    rdy_pct = 100;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = inst_valid;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL bp_hold_timeout: inst_valid=%b, need 1", inst_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (inst !== mem_word(RST_PC) || pc !== RST_PC || imem_req_valid !== 1'b0)
        begin n_err++; $display("FAIL bp_hold k=%0d: inst=%h pc=%h req=%b, need %h %h 0", k, inst, pc, imem_req_valid, mem_word(RST_PC), RST_PC); end
    end
    irdy_pct = 100;
    repeat (8) tick();
  endtask

  task automatic test_stall();
    bit got;
    logic [31:0] pc0;
    set_knobs(100, 0, 0, 100, 100, 0, 0);
    npc_force = 1'b0;
    do_reset(1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = inst_valid;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL stall_hold_timeout: inst_valid=%b, need 1", inst_valid); end
    pc0 = pc;
    tick();
    n_cmp++;
    if (inst_valid !== 1'b1 || pc !== pc0)
      begin n_err++; $display("FAIL stall_hold: iv=%b pc=%h, need 1 %h", inst_valid, pc, pc0); end
    stall_pct = 0;
    tick();
    n_cmp++;
    if (pc !== pc0) begin n_err++; $display("FAIL stall_pc: got %h, need %h", pc, pc0); end
    tick();
    n_cmp++;
    if (pc !== pc0 + 32'd4 || imem_req_valid !== 1'b1)
      begin n_err++; $display("FAIL stall_release: pc=%h req=%b, need %h 1", pc, imem_req_valid, pc0 + 32'd4); end
  endtask

  task automatic test_redirect();
    logic [31:0] a;
    bit ok;
    set_knobs(100, 0, 0, 100, 0, 0, 0);
    npc_force = 1'b1;
    npc_val = 32'h0000_3040;
    do_reset(1);
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== RST_PC) begin n_err++; $display("FAIL redir_first: ok=%0d addr=%h, need %h", ok, a, RST_PC); end
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h0000_3040) begin n_err++; $display("FAIL redir_branch: ok=%0d addr=%h, need 00003040", ok, a); end
    npc_val = 32'hFFFF_FFFC;
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL redir_top: ok=%0d addr=%h, need fffffffc", ok, a); end
    npc_force = 1'b0;
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h0000_0000) begin n_err++; $display("FAIL redir_wrap: ok=%0d addr=%h, need 00000000", ok, a); end
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h0000_0004) begin n_err++; $display("FAIL redir_after_wrap: ok=%0d addr=%h, need 00000004", ok, a); end
  endtask

  task automatic test_misalign();
    logic [31:0] a;
    bit ok;
    set_knobs(100, 0, 0, 100, 0, 0, 0);
    npc_force = 1'b1;
    npc_val = 32'h0000_3002;
    do_reset(1);
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== RST_PC) begin n_err++; $display("FAIL mis_first: ok=%0d addr=%h, need %h", ok, a, RST_PC); end
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (12) tick();
    n_cmp++;
    if (fetch_misalign !== 1'b1 || pc !== 32'h0000_3002 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
      begin n_err++; $display("FAIL mis_trap: mis=%b pc=%h req=%b iv=%b, need 1 00003002 0 0", fetch_misalign, pc, imem_req_valid, inst_valid); end
`else
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== RST_PC || fetch_misalign !== 1'b0)
      begin n_err++; $display("FAIL mis_align: ok=%0d addr=%h mis=%b, need %h 0", ok, a, fetch_misalign, RST_PC); end
`endif
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] a;
    bit ok;
    set_knobs(100, 0, 0, 100, 0, 0, 0);
    npc_force = 1'b0;
    do_reset(1);
    run_to_req(a, ok);
    min_dly = 10; max_dly = 10;
    run_to_req(a, ok);
    n_cmp++;
    if (!ok || a !== RST_PC + 32'd4) begin n_err++; $display("FAIL rw_second: ok=%0d addr=%h, need %h", ok, a, RST_PC + 32'd4); end
    tick();
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
      begin n_err++; $display("FAIL rw_waiting: req=%b iv=%b, need 0 0", imem_req_valid, inst_valid); end
    do_reset(1);
    n_cmp++;
    if (pc !== RST_PC || imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
      begin n_err++; $display("FAIL rw_reset: pc=%h req=%b iv=%b, need %h 0 0", pc, imem_req_valid, inst_valid, RST_PC); end
    min_dly = 0; max_dly = 0;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
      begin n_err++; $display("FAIL rw_restart: req=%b addr=%h, need 1 %h", imem_req_valid, imem_addr, RST_PC); end
    repeat (10) tick();
  endtask

  task automatic test_random();
    int c0;
    set_knobs(60, 0, 3, 60, 25, 20, 20);
    npc_force = 1'b0;
    do_reset(1);
    c0 = n_consumed;
    repeat (2000) tick();
    n_cmp++;
    if (n_consumed - c0 < 50)
      begin n_err++; $display("FAIL random_progress: consumed %0d, need at least 50", n_consumed - c0); end
  endtask

  initial begin
    n_consumed = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_redirect();
    test_misalign();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
